// File: rtl/program_store.sv
// Hand-loaded program RAM for the 8-bit CPU: debounced switch/button loader plus
// a zero-latency instruction read port that masks unloaded addresses with HALT.
module program_store #(
  parameter int         ADDR_W          = 8,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [7:0] HALT_WORD       = 8'hC3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              load_strobe,
  input  logic [7:0]        load_data,
  input  logic [7:0]        instruction_address,
  output logic [7:0]        instruction,
  output logic              cpu_reset,
  output logic              loading,
  output logic [ADDR_W-1:0] load_pointer,
  output logic [ADDR_W:0]   program_length,
  output logic              full
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_t;
  typedef enum logic {ARMED, WAIT_LOW} deb_t;

  state_t            state;
  deb_t              deb;
  logic [CNT_W-1:0]  deb_cnt;
  logic              mode_p0, mode_p1;
  logic              strobe_p0, strobe_p1;
  logic              counting;
  logic              accept;
  logic              write_en;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] read_addr;

  assign counting = (state == LOAD);
  assign accept   = counting && (deb == ARMED) && strobe_p1 && (deb_cnt == CNT_LAST);
  assign write_en = accept && !full;

  assign full      = (program_length == LEN_FULL);
  assign cpu_reset = (state != RUN);
  assign loading   = (state == LOAD);

  // Stage p0/p1: two-flop synchronisers, then debouncer and load FSM on synced copies
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_p0        <= 1'b0;
      mode_p1        <= 1'b0;
      strobe_p0      <= 1'b0;
      strobe_p1      <= 1'b0;
      state          <= RUN;
      deb            <= ARMED;
      deb_cnt        <= '0;
      load_pointer   <= '0;
      program_length <= '0;
    end else begin
      mode_p0   <= load_mode;
      mode_p1   <= mode_p0;
      strobe_p0 <= load_strobe;
      strobe_p1 <= strobe_p0;

      if (!counting) begin
        deb     <= ARMED;
        deb_cnt <= '0;
      end else begin
        case (deb)
          ARMED: begin
            if (!strobe_p1) begin
              deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
              deb     <= WAIT_LOW;
              deb_cnt <= '0;
            end else begin
              deb_cnt <= deb_cnt + CNT_W'(1);
            end
          end
          WAIT_LOW: begin
            if (strobe_p1) begin
              deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
              deb     <= ARMED;
              deb_cnt <= '0;
            end else begin
              deb_cnt <= deb_cnt + CNT_W'(1);
            end
          end
          default: begin
            deb     <= ARMED;
            deb_cnt <= '0;
          end
        endcase
      end

      // The pointer wraps naturally; full stops any write past the last slot.
      if (write_en) begin
        load_pointer   <= load_pointer + ADDR_W'(1);
        program_length <= program_length + (ADDR_W + 1)'(1);
      end

      case (state)
        RUN: begin
          if (mode_p1) begin
            state          <= LOAD;
            load_pointer   <= '0;
            program_length <= '0;
          end
        end
        LOAD:    if (!mode_p1) state <= RELEASE;
        RELEASE: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // RAM contents survive reset; program_length masks stale words instead.
  always_ff @(posedge clock) begin
    if (write_en) mem[load_pointer] <= load_data;
  end

  assign read_addr   = instruction_address[ADDR_W-1:0];
  assign instruction = ({1'b0, read_addr} < program_length) ? mem[read_addr] : HALT_WORD;

endmodule
